dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single-port data memory (dRAM) between two requesters: the CPU load/store path and a debug/loader port used for program/data upload and inspection.
- Sits between the core's memory-request signals and dRAM.
- Serialises accesses with req/gnt/rvalid handshakes, tracks the owner of the outstanding access, and routes read data back to that owner only.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- RD_LAT, 1, memory response latency in cycles from mem_req_o to valid mem_rdata_i; legal range 1..4.

Ports:
- CLK100MHZ  in  1  clock.
- CPU_RESETN  in  1  reset, asynchronous, active-low.
- core_req_i  in  1  core access request; held with its attributes until core_gnt_o.
- core_we_i  in  1  core write enable.
- core_be_i  in  DATA_W/8  core byte enables.
- core_addr_i  in  ADDR_W  core address.
- core_wdata_i  in  DATA_W  core write data.
- core_gnt_o  out  1  core request accepted this cycle.
- core_rvalid_o  out  1  core access complete; read data valid.
- core_rdata_o  out  DATA_W  core read data.
- dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i  in  as core  debug-port request signals.
- dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o  out  as core  debug-port responses.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data.

Behaviour:
- Reset (async, CPU_RESETN low): FSM to IDLE, owner cleared, latency counter 0, RR pointer to core. All outputs 0.
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: access outstanding; counter counts RD_LAT cycles.
- Grant slot: a cycle is a grant slot if state is IDLE, or state is WAIT and the response completes this cycle. This gives back-to-back throughput of one access per RD_LAT cycles.
- Grant: in a grant slot with at least one request pending, the winner's gnt is a one-cycle pulse, combinational in that cycle.
  - mem_req_o=1 in the same cycle, with mem_we/be/addr/wdata muxed from the winner.
  - Owner is registered; the FSM goes to (or stays in) WAIT with the counter reloaded.
- Outside a grant: mem_req_o=0 and the mem_* attributes are 0.
- Response: exactly RD_LAT cycles after a grant at cycle T, the owner's rvalid=1 at cycle T+RD_LAT, with rdata=mem_rdata_i.
  - The non-owner's rdata is 0.
  - Writes also produce rvalid; rdata is don't-care (driven from mem_rdata_i).
  - If no new grant occurs in the completion cycle, the FSM returns to IDLE.
- Fixed priority (default): dbg wins over core when both request in a grant slot. A held core request is served in the next slot where dbg_req_i=0.
- At most one access is outstanding at any time. gnt is never asserted to both requesters in the same cycle.
- A write with be=0 is a legal no-op access and still completes with rvalid.
- Protocol: dropping req before gnt is a requester error. Arbiter behaviour is then undefined, but it must not hang: a slot with no request simply stays idle.
- Reset mid-access: the outstanding response is discarded and no rvalid is issued after reset release.

Optional Feature:
- Macro DRAM_ARB_RR_EN.
- Defined: two-way round-robin. The requester granted last has lowest priority when both request; the pointer updates only on a grant and resets to favour core.
- Undefined: fixed dbg-over-core priority, no pointer register.

Decomposition:
- Package dram_arb_pkg:
  - typedef enum {ST_IDLE, ST_WAIT} arb_state_t;
  - typedef enum logic {OWN_CORE, OWN_DBG} arb_owner_t;
  - packed struct mem_req_t {we, be, addr, wdata};
  - constant RD_LAT_MAX=4.
- One sub-module arb_pick2: a combinational 2-way picker taking req vector and priority pointer, producing a one-hot grant. It is shared by the fixed and RR variants; fixed mode ties the pointer to dbg.

Test Plan:
- Core-only read, RD_LAT=1, addr 0x10, memory word 0xDEADBEEF: gnt at T, mem_req_o=1 with addr 0x10 at T, core_rvalid=1 with rdata 0xDEADBEEF at T+1, dbg_rvalid stays 0.
- Simultaneous core and dbg requests, fixed priority: dbg granted at T, core granted at T+1, rvalids at T+1 (dbg) and T+2 (core).
- Same stimulus with DRAM_ARB_RR_EN and both requesting continuously for 6 slots: grants alternate core, dbg, core, dbg, …
- RD_LAT=3, back-to-back core write (be=4'b0011, wdata 0x1234ABCD) then read of the same address: grants at T and T+3, rvalids at T+3 and T+6, read returns 0x0000ABCD over previously-zero memory.
- CPU_RESETN asserted at T+1 of a RD_LAT=3 read: all outputs 0 immediately; no rvalid after release; a fresh request is granted in the first cycle after release.
- Idle with no requests for 10 cycles: mem_req_o, gnt and rvalid all remain 0 and the FSM stays in IDLE.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the dRAM arbiter.
// Requester attributes travel as mem_req_t, sized for widths up to 32 bits.
package dram_arb_pkg;

    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX);
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;
    typedef enum logic {OWN_CORE, OWN_DBG} arb_owner_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic arb_owner_t other_owner(input arb_owner_t o);
        return (o == OWN_CORE) ? OWN_DBG : OWN_CORE;
    endfunction

    // Counter reload: the response completes when the counter reaches zero.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/dram_arbiter_pick2.sv
// Combinational two-way picker: one-hot grant, prio breaks ties.
// req[0] is the core, req[1] the debug port.
module arb_pick2
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = (prio == OWN_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// dRAM arbiter between the CPU load/store path and the debug/loader port.
// Define DRAM_ARB_RR_EN for round-robin; default is fixed dbg-over-core priority.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,

    input  logic                core_req_i,
    input  logic                core_we_i,
    input  logic [DATA_W/8-1:0] core_be_i,
    input  logic [ADDR_W-1:0]   core_addr_i,
    input  logic [DATA_W-1:0]   core_wdata_i,
    output logic                core_gnt_o,
    output logic                core_rvalid_o,
    output logic [DATA_W-1:0]   core_rdata_o,

    input  logic                dbg_req_i,
    input  logic                dbg_we_i,
    input  logic [DATA_W/8-1:0] dbg_be_i,
    input  logic [ADDR_W-1:0]   dbg_addr_i,
    input  logic [DATA_W-1:0]   dbg_wdata_i,
    output logic                dbg_gnt_o,
    output logic                dbg_rvalid_o,
    output logic [DATA_W-1:0]   dbg_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t       state;
    arb_owner_t       owner;
    logic [CNT_W-1:0] cnt;

    logic       resp_done;
    logic       slot;
    logic [1:0] req_vec;
    logic [1:0] pick;
    logic [1:0] gnt_vec;
    logic       grant_any;
    arb_owner_t winner;
    arb_owner_t prio;

    mem_req_t core_mr;
    mem_req_t dbg_mr;
    mem_req_t win_mr;

    // A slot opens when idle or when the outstanding access completes; reset closes it.
    assign resp_done = (state == ST_WAIT) && (cnt == '0);
    assign slot      = CPU_RESETN && ((state == ST_IDLE) || resp_done);
    assign req_vec   = {dbg_req_i, core_req_i};

`ifdef DRAM_ARB_RR_EN
    arb_owner_t rr_ptr;
    assign prio = rr_ptr;
`else
    assign prio = OWN_DBG;
`endif

    arb_pick2 u_pick (
        .req  (req_vec),
        .prio (prio),
        .gnt  (pick)
    );

    assign gnt_vec   = slot ? pick : 2'b00;
    assign grant_any = |gnt_vec;
    assign winner    = gnt_vec[1] ? OWN_DBG : OWN_CORE;

    assign core_mr = '{we:    core_we_i,
                       be:    ARB_BE_W'(core_be_i),
                       addr:  ARB_ADDR_W'(core_addr_i),
                       wdata: ARB_DATA_W'(core_wdata_i)};
    assign dbg_mr  = '{we:    dbg_we_i,
                       be:    ARB_BE_W'(dbg_be_i),
                       addr:  ARB_ADDR_W'(dbg_addr_i),
                       wdata: ARB_DATA_W'(dbg_wdata_i)};

    always_comb begin
        win_mr = '0;
        if (gnt_vec[1]) begin
            win_mr = dbg_mr;
        end else if (gnt_vec[0]) begin
            win_mr = core_mr;
        end
    end

    assign core_gnt_o  = gnt_vec[0];
    assign dbg_gnt_o   = gnt_vec[1];
    assign mem_req_o   = grant_any;
    assign mem_we_o    = win_mr.we;
    assign mem_be_o    = BE_W'(win_mr.be);
    assign mem_addr_o  = ADDR_W'(win_mr.addr);
    assign mem_wdata_o = DATA_W'(win_mr.wdata);

    // Read data is steered to the owner only; the other side sees zero.
    assign core_rvalid_o = resp_done && (owner == OWN_CORE);
    assign dbg_rvalid_o  = resp_done && (owner == OWN_DBG);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : '0;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= ST_IDLE;
            owner <= OWN_CORE;
            cnt   <= '0;
`ifdef DRAM_ARB_RR_EN
            rr_ptr <= OWN_CORE;
`endif
        end else begin
            if (grant_any) begin
                state <= ST_WAIT;
                owner <= winner;
                cnt   <= lat_load(RD_LAT);
`ifdef DRAM_ARB_RR_EN
                rr_ptr <= other_owner(winner);
`endif
            end else if (resp_done) begin
                state <= ST_IDLE;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: one instance at RD_LAT=1, one at RD_LAT=3, each with a memory model.
// Responses are scored against expectations queued as requests are driven.
module tb_dram_arbiter;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    typedef struct {
        bit          dbg;
        bit          has_data;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    rq_t c1, d1, c3, d3;

    logic        c1_gnt, c1_rv, d1_gnt, d1_rv, m1_req, m1_we;
    logic [31:0] c1_rd, d1_rd, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        c3_gnt, c3_rv, d3_gnt, d3_rv, m3_req, m3_we;
    logic [31:0] c3_rd, d3_rd, m3_addr, m3_wdata, m3_rdata;
    logic [3:0]  m3_be;

    int checks   = 0;
    int failures = 0;
    exp_t q1[$];
    exp_t q3[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic rq_t rd(input logic [31:0] a);
        return '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
    endfunction

    function automatic rq_t wr(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        return '{req: 1'b1, we: 1'b1, be: be, addr: a, wdata: d};
    endfunction

    function automatic exp_t ex(input bit dbg, input bit hd, input logic [31:0] d);
        return '{dbg: dbg, has_data: hd, data: d};
    endfunction

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .CLK100MHZ(clk), .CPU_RESETN(rstn),
        .core_req_i(c1.req), .core_we_i(c1.we), .core_be_i(c1.be),
        .core_addr_i(c1.addr), .core_wdata_i(c1.wdata),
        .core_gnt_o(c1_gnt), .core_rvalid_o(c1_rv), .core_rdata_o(c1_rd),
        .dbg_req_i(d1.req), .dbg_we_i(d1.we), .dbg_be_i(d1.be),
        .dbg_addr_i(d1.addr), .dbg_wdata_i(d1.wdata),
        .dbg_gnt_o(d1_gnt), .dbg_rvalid_o(d1_rv), .dbg_rdata_o(d1_rd),
        .mem_req_o(m1_req), .mem_we_o(m1_we), .mem_be_o(m1_be),
        .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata), .mem_rdata_i(m1_rdata)
    );

    dram_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .CLK100MHZ(clk), .CPU_RESETN(rstn),
        .core_req_i(c3.req), .core_we_i(c3.we), .core_be_i(c3.be),
        .core_addr_i(c3.addr), .core_wdata_i(c3.wdata),
        .core_gnt_o(c3_gnt), .core_rvalid_o(c3_rv), .core_rdata_o(c3_rd),
        .dbg_req_i(d3.req), .dbg_we_i(d3.we), .dbg_be_i(d3.be),
        .dbg_addr_i(d3.addr), .dbg_wdata_i(d3.wdata),
        .dbg_gnt_o(d3_gnt), .dbg_rvalid_o(d3_rv), .dbg_rdata_o(d3_rd),
        .mem_req_o(m3_req), .mem_we_o(m3_we), .mem_be_o(m3_be),
        .mem_addr_o(m3_addr), .mem_wdata_o(m3_wdata), .mem_rdata_i(m3_rdata)
    );

    // Memory models: word-addressed, byte-enabled writes, RD_LAT-deep read pipe
    logic [31:0] mem1 [256] = '{default: 32'h0};
    logic [31:0] mem3 [256] = '{default: 32'h0};
    logic [31:0] rp1 = 32'h0;
    logic [31:0] rp3 [3] = '{default: 32'h0};

    assign m1_rdata = rp1;
    assign m3_rdata = rp3[2];

    always @(posedge clk) begin
        if (m1_req) begin
            if (m1_we)
                for (int b = 0; b < 4; b++)
                    if (m1_be[b]) mem1[m1_addr[9:2]][b*8 +: 8] <= m1_wdata[b*8 +: 8];
            rp1 <= mem1[m1_addr[9:2]];
        end
    end

    always @(posedge clk) begin
        if (m3_req) begin
            if (m3_we)
                for (int b = 0; b < 4; b++)
                    if (m3_be[b]) mem3[m3_addr[9:2]][b*8 +: 8] <= m3_wdata[b*8 +: 8];
            rp3[0] <= mem3[m3_addr[9:2]];
        end
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    // Response scoreboards
    always @(negedge clk) begin
        exp_t e;
        chk("gnt1_excl", 32'(c1_gnt & d1_gnt), 32'h0);
        if (c1_rv || d1_rv) begin
            if (q1.size() == 0) begin
                chk("rv1_spurious", 32'({c1_rv, d1_rv}), 32'h0);
            end else begin
                e = q1.pop_front();
                chk("rv1_owner_dbg", 32'(d1_rv), 32'(e.dbg));
                chk("rv1_owner_core", 32'(c1_rv), 32'(!e.dbg));
                if (e.has_data) chk("rv1_rdata", e.dbg ? d1_rd : c1_rd, e.data);
                chk("rv1_other_rdata", e.dbg ? c1_rd : d1_rd, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("gnt3_excl", 32'(c3_gnt & d3_gnt), 32'h0);
        if (c3_rv || d3_rv) begin
            if (q3.size() == 0) begin
                chk("rv3_spurious", 32'({c3_rv, d3_rv}), 32'h0);
            end else begin
                e = q3.pop_front();
                chk("rv3_owner_dbg", 32'(d3_rv), 32'(e.dbg));
                chk("rv3_owner_core", 32'(c3_rv), 32'(!e.dbg));
                if (e.has_data) chk("rv3_rdata", e.dbg ? d3_rd : c3_rd, e.data);
                chk("rv3_other_rdata", e.dbg ? c3_rd : d3_rd, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_1"}, 32'({m1_req, m1_we, m1_be, c1_gnt, d1_gnt, c1_rv, d1_rv}), 32'h0);
        chk({tag, "_1a"}, m1_addr | m1_wdata | c1_rd | d1_rd, 32'h0);
        chk({tag, "_3"}, 32'({m3_req, m3_we, m3_be, c3_gnt, d3_gnt, c3_rv, d3_rv}), 32'h0);
        chk({tag, "_3a"}, m3_addr | m3_wdata | c3_rd | d3_rd, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit last_dbg;
        bit exp_dbg;

        rstn = 1'b0;
        c1 = '0; d1 = '0; c3 = '0; d3 = '0;
        // Requests during reset must not be granted
        c1 = rd(32'h10);
        d3 = rd(32'h10);
        smp();
        chk_all_zero("reset");
        c1 = '0; d3 = '0;
        step();
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            smp();
            chk_all_zero("idle");
            step();
        end

        // RD_LAT=1: debug write seeds memory, then core read back-to-back
        d1 = wr(4'hF, 32'h10, 32'hDEADBEEF);
        q1.push_back(ex(1'b1, 1'b0, 32'h0));
        smp();
        chk("dw_dgnt", 32'(d1_gnt), 32'h1);
        chk("dw_mreq", 32'(m1_req), 32'h1);
        chk("dw_mwe", 32'(m1_we), 32'h1);
        chk("dw_maddr", m1_addr, 32'h10);
        chk("dw_mwdata", m1_wdata, 32'hDEADBEEF);
        step();
        d1 = '0;
        c1 = rd(32'h10);
        q1.push_back(ex(1'b0, 1'b1, 32'hDEADBEEF));
        smp();
        chk("dw_rv", 32'(d1_rv), 32'h1);
        chk("cr_cgnt", 32'(c1_gnt), 32'h1);
        chk("cr_maddr", m1_addr, 32'h10);
        chk("cr_mwe", 32'(m1_we), 32'h0);
        step();
        c1 = '0;
        smp();
        chk("cr_crv", 32'(c1_rv), 32'h1);
        chk("cr_crd", c1_rd, 32'hDEADBEEF);
        chk("cr_drv", 32'(d1_rv), 32'h0);
        chk("cr_mreq_off", 32'(m1_req), 32'h0);
        chk("cr_maddr_off", m1_addr, 32'h0);
        step();

        // Simultaneous requests: dbg first (also the RR pick, core was last)
        c1 = rd(32'h10);
        d1 = rd(32'h20);
        q1.push_back(ex(1'b1, 1'b1, 32'h0));
        q1.push_back(ex(1'b0, 1'b1, 32'hDEADBEEF));
        smp();
        chk("sim_dgnt", 32'(d1_gnt), 32'h1);
        chk("sim_cgnt0", 32'(c1_gnt), 32'h0);
        chk("sim_maddr0", m1_addr, 32'h20);
        step();
        d1 = '0;
        smp();
        chk("sim_cgnt1", 32'(c1_gnt), 32'h1);
        chk("sim_drv", 32'(d1_rv), 32'h1);
        chk("sim_maddr1", m1_addr, 32'h10);
        step();
        c1 = '0;
        smp();
        chk("sim_crv", 32'(c1_rv), 32'h1);
        step();

        // Both requesting continuously for six slots
        c1 = rd(32'h10);
        d1 = rd(32'h20);
        last_dbg = 1'b0;
        for (int s = 0; s < 6; s++) begin
`ifdef DRAM_ARB_RR_EN
            exp_dbg = !last_dbg;
`else
            exp_dbg = 1'b1;
`endif
            q1.push_back(exp_dbg ? ex(1'b1, 1'b1, 32'h0) : ex(1'b0, 1'b1, 32'hDEADBEEF));
            smp();
            chk("cont_dgnt", 32'(d1_gnt), 32'(exp_dbg));
            chk("cont_cgnt", 32'(c1_gnt), 32'(!exp_dbg));
            last_dbg = exp_dbg;
            step();
        end
        // Held core request is served once dbg drops
        d1 = '0;
        q1.push_back(ex(1'b0, 1'b1, 32'hDEADBEEF));
        smp();
        chk("tail_cgnt", 32'(c1_gnt), 32'h1);
        chk("tail_dgnt", 32'(d1_gnt), 32'h0);
        step();
        c1 = '0;
        smp();
        chk("tail_crv", 32'(c1_rv), 32'h1);
        step();

        // RD_LAT=3: partial write then read of the same word
        c3 = wr(4'b0011, 32'h40, 32'h1234ABCD);
        q3.push_back(ex(1'b0, 1'b0, 32'h0));
        smp();
        chk("w3_cgnt", 32'(c3_gnt), 32'h1);
        chk("w3_mbe", 32'(m3_be), 32'h3);
        chk("w3_mwdata", m3_wdata, 32'h1234ABCD);
        chk("w3_mwe", 32'(m3_we), 32'h1);
        step();
        c3 = rd(32'h40);
        q3.push_back(ex(1'b0, 1'b1, 32'h0000ABCD));
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("w3_wait_gnt", 32'(c3_gnt), 32'h0);
            chk("w3_wait_mreq", 32'(m3_req), 32'h0);
            chk("w3_wait_rv", 32'(c3_rv), 32'h0);
            step();
        end
        smp();
        chk("r3_cgnt", 32'(c3_gnt), 32'h1);
        chk("r3_wrv", 32'(c3_rv), 32'h1);
        chk("r3_mwe", 32'(m3_we), 32'h0);
        chk("r3_maddr", m3_addr, 32'h40);
        step();
        // Byte-enable-zero write is a no-op that still completes
        c3 = wr(4'b0000, 32'h40, 32'hFFFFFFFF);
        q3.push_back(ex(1'b0, 1'b0, 32'h0));
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("r3_wait_rv", 32'(c3_rv), 32'h0);
            step();
        end
        smp();
        chk("z3_cgnt", 32'(c3_gnt), 32'h1);
        chk("z3_rrv", 32'(c3_rv), 32'h1);
        chk("z3_mbe", 32'(m3_be), 32'h0);
        step();
        c3 = rd(32'h40);
        q3.push_back(ex(1'b0, 1'b1, 32'h0000ABCD));
        step();
        step();
        smp();
        chk("z3r_cgnt", 32'(c3_gnt), 32'h1);
        chk("z3r_zrv", 32'(c3_rv), 32'h1);
        step();
        c3 = '0;
        step();
        step();
        smp();
        chk("z3r_rv", 32'(c3_rv), 32'h1);
        step();

        // Reset one cycle into a read: response discarded
        c3 = rd(32'h40);
        smp();
        chk("rst3_cgnt", 32'(c3_gnt), 32'h1);
        step();
        c3 = '0;
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        smp();
        chk_all_zero("midrst_hold");
        step();
        rstn = 1'b1;
        c3 = rd(32'h40);
        q3.push_back(ex(1'b0, 1'b1, 32'h0000ABCD));
        smp();
        chk("post_rst_cgnt", 32'(c3_gnt), 32'h1);
        chk("post_rst_norv", 32'(c3_rv), 32'h0);
        step();
        c3 = '0;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("post_rst_wait", 32'(c3_rv), 32'h0);
            step();
        end
        smp();
        chk("post_rst_rv", 32'(c3_rv), 32'h1);
        step();

        for (int i = 0; i < 4; i++) begin
            smp();
            chk_all_zero("final_idle");
            step();
        end
        chk("q1_empty", 32'(q1.size()), 32'h0);
        chk("q3_empty", 32'(q3.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
